// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned imem requests under a
// credit limit, and buffers returned words with their PCs for the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;

  logic [31:0]   r_pcq [DEPTH];
  logic [PW-1:0] r_pcq_rd;
  logic [PW-1:0] r_pcq_wr;

  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_inst [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;

  logic        w_credit;
  logic        w_accept;
  logic        w_rsp;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_redirect_tgt;
  logic [31:0] w_rsp_pc;

  // Credit counts both in-flight requests and buffered words, so the FIFO cannot overflow.
  assign w_credit = ((CW+1)'(r_outst) + (CW+1)'(r_count)) < (CW+1)'(DEPTH);

  assign imem_req_valid = rst_n && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp    = imem_rsp_valid && (r_outst != '0);
  assign w_drop   = w_rsp && (redirect_valid || (r_discard != '0));
  assign w_push   = w_rsp && !w_drop;
  assign w_rsp_pc = r_pcq[r_pcq_rd];

  assign inst_valid = rst_n && !redirect_valid && (r_count != '0);
  assign inst       = r_fifo_inst[r_rd];
  assign inst_pc    = r_fifo_pc[r_rd];
  assign w_pop      = inst_valid && inst_ready;

  assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_pcq_rd   <= '0;
      r_pcq_wr   <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pcq[i]       <= '0;
        r_fifo_pc[i]   <= '0;
        r_fifo_inst[i] <= '0;
      end
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_tgt;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      // PC queue tracks in-flight requests; every response, kept or dropped, retires one.
      if (w_accept) begin
        r_pcq[r_pcq_wr] <= r_fetch_pc;
        r_pcq_wr        <= r_pcq_wr + PW'(1);
      end
      if (w_rsp) begin
        r_pcq_rd <= r_pcq_rd + PW'(1);
      end

      if (w_accept && !w_rsp) begin
        r_outst <= r_outst + CW'(1);
      end else if (!w_accept && w_rsp) begin
        r_outst <= r_outst - CW'(1);
      end

      // On redirect every still-outstanding response becomes stale.
      if (redirect_valid) begin
        r_discard <= r_outst - CW'(w_rsp);
      end else if (w_rsp && (r_discard != '0)) begin
        r_discard <= r_discard - CW'(1);
      end

      if (redirect_valid) begin
        r_count <= '0;
        r_rd    <= '0;
        r_wr    <= '0;
      end else begin
        if (w_push) begin
          r_fifo_pc[r_wr]   <= w_rsp_pc;
          r_fifo_inst[r_wr] <= imem_rsp_data;
          r_wr              <= r_wr + PW'(1);
        end
        if (w_pop) begin
          r_rd <= r_rd + PW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a request-level memory/decoder model
// predicts each delivered {pc, inst} and the request stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          t;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  req_t        pend[$];
  exp_t        exp_q[$];
  logic [31:0] m_pc = RESET_PC;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int accepts = 0;

  int lat = 1;
  int rdy_pct = 100;
  int mrdy_pct = 100;
  int rsp_pct = 100;
  int redir_pct = 0;
  bit toggle_mode = 1'b0;
  bit nrst = 1'b0;
  bit force_redirect = 1'b0;
  logic [31:0] force_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Monitor: compares DUT outputs against the model and retires delivered instructions.
  bit prev_rst_low = 1'b0;
  always @(negedge clk) begin
    bit ev;
    bit erv;
    erv = rst_n && !redirect_valid && ((pend.size() + exp_q.size()) < DEPTH);
    ev  = rst_n && !redirect_valid && (exp_q.size() > 0);
    if (!rst_n && prev_rst_low) begin
      chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
      chk("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
      chk("rst_inst_valid", 64'(inst_valid), 64'(0));
      chk("rst_inst", 64'(inst), 64'(0));
      chk("rst_inst_pc", 64'(inst_pc), 64'(0));
    end else if (rst_n) begin
      chk("req_valid", 64'(imem_req_valid), 64'(erv));
      if (erv) chk("req_addr", 64'(imem_req_addr), 64'(m_pc));
      chk("inst_valid", 64'(inst_valid), 64'(ev));
      if (ev) begin
        chk("inst_pc", 64'(inst_pc), 64'(exp_q[0].pc));
        chk("inst", 64'(inst), 64'(exp_q[0].data));
        if (inst_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
    prev_rst_low = !rst_n;
  end

  // One clock: sample handshake, update the model for the finished cycle, drive the next.
  task automatic cycle();
    bit   acc;
    req_t h;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pend.delete();
      exp_q.delete();
      m_pc = RESET_PC;
    end else begin
      if (imem_rsp_valid && pend.size() > 0) begin
        h = pend.pop_front();
        if (!redirect_valid && !h.stale) exp_q.push_back('{h.addr, mem_word(h.addr)});
      end
      if (redirect_valid) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end
      if (acc) begin
        pend.push_back('{m_pc, cyc, 1'b0});
        m_pc = m_pc + 32'd4;
        accepts++;
      end
    end
    cyc++;

    rst_n = nrst;
    if (force_redirect) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_target;
      force_redirect = 1'b0;
    end else begin
      redirect_valid = nrst && ($urandom_range(99) < 32'(redir_pct));
      redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFFD : $urandom;
    end
    if (nrst && pend.size() > 0 && cyc >= pend[0].t + lat && $urandom_range(99) < 32'(rsp_pct)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = nrst && pend.size() == 0 && ($urandom_range(99) < 3);
      imem_rsp_data  = $urandom;
    end
    inst_ready     = $urandom_range(99) < 32'(rdy_pct);
    imem_req_ready = toggle_mode ? cyc[0] : ($urandom_range(99) < 32'(mrdy_pct));
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) cycle();
    nrst = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;

    // Free-run, L=1: one instruction per cycle in steady state.
    do_reset();
    repeat (6) cycle();
    pops = 0;
    repeat (20) cycle();
    chk("throughput", 64'(pops), 64'(20));

    // Decoder stall: exactly DEPTH requests, then ordered delivery after release.
    rdy_pct = 0;
    do_reset();
    accepts = 0;
    repeat (10) cycle();
    chk("stall_accepts", 64'(accepts), 64'(DEPTH));
    rdy_pct = 100;
    repeat (10) cycle();

    // L=3 redirect to an unaligned target while requests are in flight.
    lat = 3;
    do_reset();
    repeat (5) cycle();
    force_redirect = 1'b1; force_target = 32'h0000_0103;
    repeat (15) cycle();

    // Memory ready toggling every cycle.
    toggle_mode = 1'b1;
    repeat (30) cycle();
    toggle_mode = 1'b0;

    // PC wrap past the top of the address space.
    lat = 1;
    force_redirect = 1'b1; force_target = 32'hFFFF_FFFC;
    repeat (10) cycle();

    // Randomized mixed traffic with a mid-stream reset.
    for (int p = 0; p < 10; p++) begin
      lat       = 1 + int'($urandom_range(3));
      rdy_pct   = 40 + int'($urandom_range(60));
      mrdy_pct  = 40 + int'($urandom_range(60));
      rsp_pct   = 50 + int'($urandom_range(50));
      redir_pct = int'($urandom_range(8));
      if (p == 5) do_reset();
      repeat (200) cycle();
    end

    // Drain: no new requests, everything outstanding must be delivered.
    redir_pct = 0; rdy_pct = 100; mrdy_pct = 0; rsp_pct = 100;
    for (int i = 0; i < 100 && (pend.size() + exp_q.size()) > 0; i++) cycle();
    chk("drain", 64'(pend.size() + exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
